// File: rtl/ripemd160_ctrl.sv
// Hash160 RIPEMD-160 sequencer: pads a SHA-256 digest into one block, launches
// the left/right line cores, samples their results and performs the final combine.
module ripemd160_ctrl #(
  parameter int CORE_LAT = 83,
  parameter int CNT_W    = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_digest,
  output logic         core_start,
  output logic [511:0] core_block,
  input  logic         core_l_valid,
  input  logic [159:0] core_l_ans,
  input  logic         core_r_valid,
  input  logic [159:0] core_r_ans,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [159:0] out_digest,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, COMBINE, DONE} state_t;

  localparam logic [31:0] IV0 = 32'h67452301;
  localparam logic [31:0] IV1 = 32'hefcdab89;
  localparam logic [31:0] IV2 = 32'h98badcfe;
  localparam logic [31:0] IV3 = 32'h10325476;
  localparam logic [31:0] IV4 = 32'hc3d2e1f0;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [159:0]     l_ans, r_ans;
  logic             sample;
  logic [31:0]      sum0, sum1, sum2, sum3, sum4;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Digest bytes are big-endian, RIPEMD words are little-endian.
  function automatic logic [511:0] pad_block(input logic [255:0] d);
    logic [511:0] blk;
    blk = '0;
    for (int i = 0; i < 8; i++)
      blk[32*i +: 32] = bswap(d[255-32*i -: 32]);
    blk[8*32 +: 32]  = 32'h00000080;
    blk[14*32 +: 32] = 32'h00000100;
    return blk;
  endfunction

  assign sample = (state == WAIT) && (cnt == CNT_W'(CORE_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (sample) state_next = COMBINE;
      COMBINE: state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    core_start = (state == LAUNCH);
    out_valid  = (state == DONE);
    busy       = (state != IDLE);
  end

  // Result words: ans = {a, b, c, d, e}, a in the top 32 bits.
  assign sum0 = IV1 + l_ans[95:64]   + r_ans[63:32];
  assign sum1 = IV2 + l_ans[63:32]   + r_ans[31:0];
  assign sum2 = IV3 + l_ans[31:0]    + r_ans[159:128];
  assign sum3 = IV4 + l_ans[159:128] + r_ans[127:96];
  assign sum4 = IV0 + l_ans[127:96]  + r_ans[95:64];

  always_ff @(posedge clk) begin
    if (rst) begin
      core_block <= '0;
      cnt        <= '0;
      l_ans      <= '0;
      r_ans      <= '0;
      out_digest <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (in_valid) core_block <= pad_block(in_digest);
        LAUNCH:  cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (sample) begin
            l_ans <= core_l_ans;
            r_ans <= core_r_ans;
            if (!core_l_valid || !core_r_valid) err <= 1'b1;
          end
        end
        COMBINE: out_digest <= {bswap(sum0), bswap(sum1), bswap(sum2), bswap(sum3), bswap(sum4)};
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ripemd160_ctrl.md
Name: ripemd160_ctrl

Overview:
- Sequencer for the two RIPEMD-160 line cores, left (stage 1) and right (stage 2), in the Hash160 pipeline.
- Accepts the 256-bit SHA-256 digest and builds the single padded 512-bit RIPEMD block from it.
- Launches both line cores together, waits a fixed latency and samples both line results.
- Performs the final RIPEMD-160 combine with the IV and presents the 160-bit digest on a valid/ready handshake.

Parameters:
- CORE_LAT, 83: cycles from launch pulse to sampling of core results; must be ≥ core round latency.
- CNT_W, 7: width of the latency counter; must satisfy 2^CNT_W > CORE_LAT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high. One clock domain.
- in_valid  in  1  digest input valid.
- in_ready  out  1  controller can accept a digest.
- in_digest  in  256  SHA-256 digest. Byte 0 = [255:248].
- core_start  out  1  one-cycle launch pulse to both cores.
- core_block  out  512  padded block. Word w[i] = core_block[32i+31:32i].
- core_l_valid  in  1  left core done (may be sticky).
- core_l_ans  in  160  left result {aL,bL,cL,dL,eL}.
- core_r_valid  in  1  right core done (may be sticky).
- core_r_ans  in  160  right result {aR,bR,cR,dR,eR}.
- out_valid  out  1  digest valid.
- out_ready  in  1  consumer accepts digest.
- out_digest  out  160  RIPEMD-160 digest. Byte 0 = [159:152].
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky; set if either core valid is low at sample time.

Behaviour:
- Reset values: in_ready=1, core_start=0, core_block=0, out_valid=0, out_digest=0, busy=0, err=0. State=IDLE, counter=0.
- Reset mid-operation abandons the current job. Cores are not reset by this block.
- States: IDLE, LAUNCH, WAIT, COMBINE, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&in_ready: register the padded block into core_block, go to LAUNCH.
- Padding, with digest bytes b0..b31:
  - w[i] = {b(4i+3), b(4i+2), b(4i+1), b(4i)} for i = 0..7.
  - w8 = 32'h00000080.
  - w9..w13 = 0.
  - w14 = 32'h00000100 (256-bit length).
  - w15 = 0.
  - core_block is held stable from LAUNCH until the next accept.
- LAUNCH
  - core_start=1 for exactly this one cycle.
  - Counter cleared to 0. Go to WAIT.
- WAIT
  - Counter increments every cycle.
  - When counter == CORE_LAT-1: sample core_l_ans and core_r_ans into registers.
  - At the same time, set err if !core_l_valid or !core_r_valid.
  - Go to COMBINE.
  - Core valids are ignored outside this sample cycle; they may be sticky from a prior job.
- COMBINE (one cycle), all adds mod 2^32, IV h0..h4 = 67452301, efcdab89, 98badcfe, 10325476, c3d2e1f0:
  - H0 = h1+cL+dR
  - H1 = h2+dL+eR
  - H2 = h3+eL+aR
  - H3 = h4+aL+bR
  - H4 = h0+bL+cR
  - out_digest = {bswap(H0), …, bswap(H4)}, where bswap reverses byte order within each word.
  - Go to DONE.
- DONE
  - out_valid=1; out_digest is held stable.
  - On out_ready: out_valid drops next cycle and state returns to IDLE.
- Throughput and latency:
  - One job in flight at a time. in_ready=0 in every state except IDLE.
  - Accept to out_valid = CORE_LAT+3 cycles.
- Boundary conditions:
  - out_ready held high: DONE lasts exactly one cycle.
  - in_valid asserted in DONE: not accepted until the cycle after returning to IDLE.
  - err is cleared only by rst.

Test Plan:
- Reset → all outputs at reset values; in_ready=1; busy=0; no core_start.
- in_digest=0 → core_block words w8=00000080, w14=00000100, all others 0. core_start pulses exactly once, one cycle after accept.
- in_digest=00 01 02 … 1f → w0=03020100, w7=1f1e1d1c.
- Stub cores return all-zero ans with valid high → out_digest = 89abcdef_fedcba98_76543210_f0e1d2c3_01234567. out_valid rises CORE_LAT+3 cycles after accept; err=0.
- Hold out_ready=0 for 10 cycles in DONE → out_valid and out_digest stay stable, in_ready=0. Raising out_ready → IDLE next cycle. A back-to-back second digest is then accepted and completes correctly.
- Stub right core never asserts valid → err=1 after sampling; out_valid still asserted. rst asserted mid-WAIT in a separate run → IDLE next cycle, in_ready=1, err=0.
